// File: rtl/diffeq_operand_sender.sv
// Sends four operand nibbles to a differential-equation solver, pulses go,
// then waits (with timeout) for the solver result and holds it for a consumer.
//
// state    | meaning
// S_IDLE   | ready for a new operand set
// S_SEND_X | drive x, load_x high
// S_SEND_DX| drive dx, load_dx high
// S_SEND_A | drive a, load_a high
// S_SEND_U | drive u, load_u high
// S_GO     | one-cycle go pulse, timeout counter cleared
// S_WAIT   | waiting for sol_done or timeout expiry
// S_RESULT | result held until res_valid && res_ready
module diffeq_operand_sender #(
  parameter int NIB_W   = 4,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NIB_W-1:0]        x_in,
  input  logic [NIB_W-1:0]        dx_in,
  input  logic [NIB_W-1:0]        u_in,
  input  logic [NIB_W-1:0]        a_in,
  output logic [NIB_W-1:0]        in,
  output logic                    load_x,
  output logic                    load_dx,
  output logic                    load_a,
  output logic                    load_u,
  output logic                    go,
  input  logic                    sol_done,
  input  logic signed [OUT_W-1:0] sol_y,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [OUT_W-1:0] res_y,
  output logic                    res_timeout,
  output logic                    busy
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_X, S_SEND_DX, S_SEND_A, S_SEND_U, S_GO, S_WAIT, S_RESULT
  } state_t;

  state_t state, state_nxt;

  logic [NIB_W-1:0] x_q, dx_q, u_q, a_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             expired;

  assign expired = (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_valid) state_nxt = S_SEND_X;
      S_SEND_X:  state_nxt = S_SEND_DX;
      S_SEND_DX: state_nxt = S_SEND_A;
      S_SEND_A:  state_nxt = S_SEND_U;
      S_SEND_U:  state_nxt = S_GO;
      S_GO:      state_nxt = S_WAIT;
      S_WAIT:    if (sol_done || expired) state_nxt = S_RESULT;
      S_RESULT:  if (res_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in        = '0;
    load_x    = 1'b0;
    load_dx   = 1'b0;
    load_a    = 1'b0;
    load_u    = 1'b0;
    go        = 1'b0;
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    res_valid = (state == S_RESULT);
    case (state)
      S_SEND_X:  begin in = x_q;  load_x  = 1'b1; end
      S_SEND_DX: begin in = dx_q; load_dx = 1'b1; end
      S_SEND_A:  begin in = a_q;  load_a  = 1'b1; end
      S_SEND_U:  begin in = u_q;  load_u  = 1'b1; end
      S_GO:      go = 1'b1;
      default:   ;
    endcase
  end

  // Operands are only sampled on the IDLE accept, so requests while busy are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q  <= '0;
      dx_q <= '0;
      u_q  <= '0;
      a_q  <= '0;
    end else if (state == S_IDLE && req_valid) begin
      x_q  <= x_in;
      dx_q <= dx_in;
      u_q  <= u_in;
      a_q  <= a_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == S_GO) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT && !sol_done && !expired) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // sol_done takes priority over a simultaneous expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_y       <= '0;
      res_timeout <= 1'b0;
    end else if (state == S_WAIT) begin
      if (sol_done) begin
        res_y       <= sol_y;
        res_timeout <= 1'b0;
      end else if (expired) begin
        res_y       <= '0;
        res_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_diffeq_operand_sender.sv
// Directed bench for diffeq_operand_sender with TIMEOUT=8.
module tb_diffeq_operand_sender;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        x_in, dx_in, u_in, a_in;
  logic [3:0]        nib;
  logic              load_x, load_dx, load_a, load_u;
  logic              go;
  logic              sol_done;
  logic signed [15:0] sol_y;
  logic              res_valid;
  logic              res_ready;
  logic signed [15:0] res_y;
  logic              res_timeout;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  diffeq_operand_sender #(.NIB_W(4), .OUT_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .x_in(x_in), .dx_in(dx_in), .u_in(u_in), .a_in(a_in),
    .in(nib),
    .load_x(load_x), .load_dx(load_dx), .load_a(load_a), .load_u(load_u),
    .go(go),
    .sol_done(sol_done), .sol_y(sol_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_y(res_y), .res_timeout(res_timeout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int strobes();
    return int'({load_x, load_dx, load_a, load_u});
  endfunction

  task automatic set_ops(input logic [3:0] x, input logic [3:0] dx,
                         input logic [3:0] u, input logic [3:0] a);
    x_in = x; dx_in = dx; u_in = u; a_in = a;
  endtask

  // Checks the four SEND cycles (x, dx, a, u order) and the GO cycle; ends in WAIT.
  task automatic check_sends(input logic [3:0] ex, input logic [3:0] edx,
                             input logic [3:0] ea, input logic [3:0] eu);
    logic [3:0] vals [4];
    vals[0] = ex; vals[1] = edx; vals[2] = ea; vals[3] = eu;
    for (int i = 0; i < 4; i++) begin
      check("send_in", int'(nib), int'(vals[i]));
      check("send_strobe", strobes(), int'(4'b1000 >> i));
      check("send_go", int'(go), 0);
      check("send_ready", int'(req_ready), 0);
      tick();
    end
    check("go_pulse", int'(go), 1);
    check("go_in", int'(nib), 0);
    check("go_strobe", strobes(), 0);
    tick();
    check("wait_go", int'(go), 0);
    check("wait_busy", int'(busy), 1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; sol_done = 1'b0; sol_y = '0; res_ready = 1'b0;
    set_ops(4'd0, 4'd0, 4'd0, 4'd0);
    #12;
    check("rst_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_in", int'(nib), 0);
    check("rst_strobe", strobes(), 0);
    check("rst_go", int'(go), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_y", int'(res_y), 0);
    check("rst_res_timeout", int'(res_timeout), 0);
    tick();
    reset = 1'b0;
    tick();

    // Basic transaction, solver answers -37 three cycles after go.
    set_ops(4'd2, 4'd1, 4'd3, 4'd5);
    check("idle_ready", int'(req_ready), 1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    set_ops(4'd0, 4'd0, 4'd0, 4'd0);
    check_sends(4'd2, 4'd1, 4'd5, 4'd3);
    tick();
    tick();
    sol_done = 1'b1; sol_y = -16'sd37;
    tick();
    sol_done = 1'b0; sol_y = '0;
    check("res_valid", int'(res_valid), 1);
    check("res_y", int'(res_y), -37);
    check("res_timeout", int'(res_timeout), 0);
    for (int i = 0; i < 4; i++) begin
      sol_done = (i == 1);
      sol_y = 16'sd55;
      tick();
      check("hold_valid", int'(res_valid), 1);
      check("hold_y", int'(res_y), -37);
      check("hold_ready", int'(req_ready), 0);
    end
    sol_done = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("release_valid", int'(res_valid), 0);
    check("release_ready", int'(req_ready), 1);
    check("release_busy", int'(busy), 0);

    // Timeout: 8 WAIT cycles with no sol_done.
    set_ops(4'd7, 4'd6, 4'd4, 4'd9);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check_sends(4'd7, 4'd6, 4'd9, 4'd4);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("to_wait_valid", int'(res_valid), 0);
    end
    tick();
    check("to_valid", int'(res_valid), 1);
    check("to_res_y", int'(res_y), 0);
    check("to_flag", int'(res_timeout), 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("to_release", int'(req_ready), 1);

    // sol_done on the expiry cycle wins.
    set_ops(4'd1, 4'd1, 4'd1, 4'd1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check_sends(4'd1, 4'd1, 4'd1, 4'd1);
    for (int i = 1; i < 8; i++) tick();
    check("exp_wait_valid", int'(res_valid), 0);
    sol_done = 1'b1; sol_y = 16'sd100;
    tick();
    sol_done = 1'b0;
    check("exp_valid", int'(res_valid), 1);
    check("exp_res_y", int'(res_y), 100);
    check("exp_flag", int'(res_timeout), 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset during SEND_DX aborts with no go.
    set_ops(4'd3, 4'd4, 4'd5, 4'd6);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("sdx_strobe", strobes(), 4'b0100);
    reset = 1'b1;
    #1;
    check("rst_mid_strobe", strobes(), 0);
    check("rst_mid_in", int'(nib), 0);
    check("rst_mid_ready", int'(req_ready), 1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sol_done = (i == 2);
      sol_y = 16'sd12;
      tick();
      check("post_rst_go", int'(go), 0);
      check("post_rst_strobe", strobes(), 0);
      check("post_rst_ready", int'(req_ready), 1);
      check("post_rst_valid", int'(res_valid), 0);
    end
    sol_done = 1'b0;

    // req_valid held through WAIT with new operands; they go out only next time.
    set_ops(4'd1, 4'd2, 4'd3, 4'd4);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check_sends(4'd1, 4'd2, 4'd4, 4'd3);
    set_ops(4'd9, 4'd10, 4'd11, 4'd12);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("busy_strobe", strobes(), 0);
      check("busy_ready", int'(req_ready), 0);
    end
    sol_done = 1'b1; sol_y = -16'sd2;
    tick();
    sol_done = 1'b0;
    check("b_res_y", int'(res_y), -2);
    tick();
    check("b_hold_strobe", strobes(), 0);
    check("b_hold_valid", int'(res_valid), 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("b_idle_ready", int'(req_ready), 1);
    check("b_idle_strobe", strobes(), 0);
    tick();
    req_valid = 1'b0;
    check_sends(4'd9, 4'd10, 4'd12, 4'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
